bioee_clkdiv_multi: RTL and testbench

//  Multi-channel programmable clock divider for the BioEE potentiostat timing tree (DAC update, ADC

---
 rtl/bioee_clkdiv_pkg.sv | 9 +
 rtl/bioee_clkdiv_chan.sv | 125 ++++++++++++
 rtl/bioee_clkdiv_multi.sv | 41 ++++
 tb/tb_bioee_clkdiv_multi.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bioee_clkdiv_pkg.sv
// Shared constants and types for the BioEE multi-channel clock divider.
package bioee_clkdiv_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned DIV_MIN   = 2;

  typedef enum logic [0:0] {CH_IDLE, CH_RUN} ch_state_e;

endpackage

// File: rtl/bioee_clkdiv_chan.sv
// One divider channel: period counter, shadow/active divider registers and an IDLE/RUN FSM.
module bioee_clkdiv_chan
  import bioee_clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load_i,
  input  logic             sync_start_i,
  output logic             clkout_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic             load_ack_o,
  output logic             load_err_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             load_ack_q, load_ack_d;
  logic             load_err_q, load_err_d;
  logic             at_end;

  assign at_end = (cnt_q == active_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    tick_d     = 1'b0;
    load_ack_d = 1'b0;
    load_err_d = 1'b0;

    unique case (state_q)
      CH_IDLE: begin
        if (enable_i) begin
          state_d    = CH_RUN;
          cnt_d      = CNT_W'(1);
          active_d   = shadow_q;
          tick_d     = 1'b1;
          load_ack_d = pending_q;
          pending_d  = 1'b0;
        end
      end
      CH_RUN: begin
        // sync_start only restarts a channel that is still requested to run
        if (enable_i && (at_end || sync_start_i)) begin
          cnt_d  = CNT_W'(1);
          tick_d = 1'b1;
          if (pending_q) begin
            active_d   = shadow_q;
            load_ack_d = 1'b1;
            pending_d  = 1'b0;
          end
        end else if (at_end) begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Evaluated after the boundary logic so a load landing on a boundary waits for the next one
    if (div_load_i) begin
      if (div_i >= CNT_W'(DIV_MIN)) begin
        shadow_d  = div_i;
        pending_d = 1'b1;
      end else begin
        load_err_d = 1'b1;
      end
    end

    busy_d   = (state_d == CH_RUN);
    clkout_d = busy_d && (cnt_d <= (active_d >> 1));
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CH_IDLE;
      cnt_q      <= '0;
      active_q   <= CNT_W'(DEFAULT_DIV);
      shadow_q   <= CNT_W'(DEFAULT_DIV);
      pending_q  <= 1'b0;
      clkout_q   <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      load_ack_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      clkout_q   <= clkout_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      load_ack_q <= load_ack_d;
      load_err_q <= load_err_d;
    end
  end

  assign clkout_o   = clkout_q;
  assign tick_o     = tick_q;
  assign busy_o     = busy_q;
  assign load_ack_o = load_ack_q;
  assign load_err_o = load_err_q;

endmodule

// File: rtl/bioee_clkdiv_multi.sv
// BioEE timing-tree clock divider: NUM_CH independent channels sharing one clock and sync strobe.
module bioee_clkdiv_multi
  import bioee_clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                    clkin,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    sync_start,
  output logic [NUM_CH-1:0]       clkout,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       load_ack,
  output logic [NUM_CH-1:0]       load_err
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    bioee_clkdiv_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clkin        (clkin),
      .rst_n        (rst_n),
      .enable_i     (enable[c]),
      .div_i        (div_in[c*CNT_W +: CNT_W]),
      .div_load_i   (div_load[c]),
      .sync_start_i (sync_start),
      .clkout_o     (clkout[c]),
      .tick_o       (tick[c]),
      .busy_o       (busy[c]),
      .load_ack_o   (load_ack[c]),
      .load_err_o   (load_err[c])
    );
  end

endmodule

// File: tb/tb_bioee_clkdiv_multi.sv
// Self-checking bench for bioee_clkdiv_multi: directed scenarios plus randomized traffic vs a model.
module tb_bioee_clkdiv_multi;

  localparam int NCH = 4;
  localparam int CW  = 16;

  logic              clkin = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    enable;
  logic [NCH*CW-1:0] div_in;
  logic [NCH-1:0]    div_load;
  logic              sync_start;
  logic [NCH-1:0]    clkout, tick, busy, load_ack, load_err;

  bioee_clkdiv_multi #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (2)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .enable     (enable),
    .div_in     (div_in),
    .div_load   (div_load),
    .sync_start (sync_start),
    .clkout     (clkout),
    .tick       (tick),
    .busy       (busy),
    .load_ack   (load_ack),
    .load_err   (load_err)
  );

  always #5 clkin = ~clkin;

  int n_cmp = 0;
  int n_err = 0;

  // Model: each channel is either stopped or at position m_phase within a period of m_n cycles
  bit             m_run[NCH];
  bit             m_pend[NCH];
  int             m_phase[NCH];
  int             m_n[NCH];
  int             m_shadow[NCH];
  logic [NCH-1:0] e_clk, e_tick, e_busy, e_ack, e_err;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c]    = 1'b0;
      m_pend[c]   = 1'b0;
      m_phase[c]  = 0;
      m_n[c]      = 2;
      m_shadow[c] = 2;
    end
    e_clk = '0; e_tick = '0; e_busy = '0; e_ack = '0; e_err = '0;
  endtask

  task automatic model_update();
    for (int c = 0; c < NCH; c++) begin
      int  d;
      bit  last;
      d         = int'(div_in[c*CW +: CW]);
      last      = m_run[c] && (m_phase[c] == m_n[c] - 1);
      e_tick[c] = 1'b0;
      e_ack[c]  = 1'b0;
      e_err[c]  = 1'b0;
      if (!m_run[c]) begin
        if (enable[c]) begin
          m_run[c]   = 1'b1;
          m_phase[c] = 0;
          m_n[c]     = m_shadow[c];
          e_tick[c]  = 1'b1;
          e_ack[c]   = m_pend[c];
          m_pend[c]  = 1'b0;
        end
      end else if (enable[c] && (last || sync_start)) begin
        m_phase[c] = 0;
        e_tick[c]  = 1'b1;
        if (m_pend[c]) begin
          m_n[c]    = m_shadow[c];
          e_ack[c]  = 1'b1;
          m_pend[c] = 1'b0;
        end
      end else if (last) begin
        m_run[c] = 1'b0;
      end else begin
        m_phase[c]++;
      end
      if (div_load[c]) begin
        if (d >= 2) begin
          m_shadow[c] = d;
          m_pend[c]   = 1'b1;
        end else begin
          e_err[c] = 1'b1;
        end
      end
      e_busy[c] = m_run[c];
      e_clk[c]  = m_run[c] && (m_phase[c] < m_n[c] / 2);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    model_update();
    @(negedge clkin);
    div_load   = '0;
    sync_start = 1'b0;
  endtask

  function automatic bit any_run();
    for (int c = 0; c < NCH; c++) if (m_run[c]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_div(input int c, input int v);
    div_in[c*CW +: CW] = CW'(v);
    div_load[c]        = 1'b1;
  endtask

  task automatic quiesce();
    enable = '0;
    for (int i = 0; i < 64 && any_run(); i++) step();
    n_cmp++;
    if (busy !== '0 || any_run()) begin
      n_err++;
      $display("FAIL quiesce: busy=%b model_running=%0d required busy=0", busy, any_run());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = '0; div_in = '0; div_load = '0; sync_start = 1'b0;
    model_reset();
    #12;
    n_cmp++;
    if ({clkout, tick, busy, load_ack, load_err} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: outs=%h required 0", {clkout, tick, busy, load_ack, load_err});
    end
    @(negedge clkin);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({clkout, tick, busy, load_ack, load_err} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: outs=%h required 0", {clkout, tick, busy, load_ack, load_err});
    end
  endtask

  task automatic test_even();
    int ns[2] = '{2, 4};
    foreach (ns[k]) begin
      quiesce();
      set_div(0, ns[k]);
      step();
      enable[0] = 1'b1;
      for (int i = 0; i < 4 * ns[k]; i++) begin
        logic ec, et;
        step();
        ec = ((i % ns[k]) < ns[k] / 2);
        et = ((i % ns[k]) == 0);
        n_cmp++;
        if ({clkout[0], tick[0]} !== {ec, et} ||
            {clkout, tick, busy, load_ack, load_err} !== {e_clk, e_tick, e_busy, e_ack, e_err}) begin
          n_err++;
          $display("FAIL even_n%0d cyc%0d: clk/tick=%b%b req=%b%b outs=%h model=%h", ns[k], i,
                   clkout[0], tick[0], ec, et, {clkout, tick, busy, load_ack, load_err},
                   {e_clk, e_tick, e_busy, e_ack, e_err});
        end
      end
    end
  endtask

  task automatic test_odd();
    int ns[2] = '{5, 3};
    foreach (ns[k]) begin
      int ticks, highs;
      ticks = 0; highs = 0;
      quiesce();
      set_div(0, ns[k]);
      step();
      enable[0] = 1'b1;
      for (int i = 0; i < 100 * ns[k]; i++) begin
        step();
        ticks += int'(tick[0]);
        highs += int'(clkout[0]);
        n_cmp++;
        if ({clkout, tick, busy, load_ack, load_err} !== {e_clk, e_tick, e_busy, e_ack, e_err}) begin
          n_err++;
          $display("FAIL odd_n%0d cyc%0d: outs=%h model=%h", ns[k], i,
                   {clkout, tick, busy, load_ack, load_err}, {e_clk, e_tick, e_busy, e_ack, e_err});
        end
      end
      n_cmp++;
      if (ticks != 100 || highs != 100 * (ns[k] / 2)) begin
        n_err++;
        $display("FAIL odd_count_n%0d: ticks=%0d highs=%0d required %0d %0d", ns[k], ticks, highs,
                 100, 100 * (ns[k] / 2));
      end
    end
  endtask

  task automatic test_reload();
    int t1, t2, acks, ack_at;
    t1 = -1; t2 = -1; acks = 0; ack_at = -1;
    quiesce();
    set_div(0, 6);
    step();
    enable[0] = 1'b1;
    for (int i = 0; i < 12 && !(m_run[0] && m_phase[0] == 2); i++) step();
    set_div(0, 10);
    step();
    for (int i = 1; i <= 20; i++) begin
      step();
      if (tick[0]) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
      if (load_ack[0]) begin
        acks++;
        ack_at = i;
      end
      n_cmp++;
      if ({clkout, tick, busy, load_ack, load_err} !== {e_clk, e_tick, e_busy, e_ack, e_err}) begin
        n_err++;
        $display("FAIL reload cyc%0d: outs=%h model=%h", i,
                 {clkout, tick, busy, load_ack, load_err}, {e_clk, e_tick, e_busy, e_ack, e_err});
      end
    end
    n_cmp++;
    if (t1 != 3 || t2 != 13 || acks != 1 || ack_at != 3) begin
      n_err++;
      $display("FAIL reload_timing: ticks@%0d,%0d acks=%0d@%0d required ticks@3,13 acks=1@3",
               t1, t2, acks, ack_at);
    end
  endtask

  task automatic test_load_err();
    int acks;
    acks = 0;
    quiesce();
    set_div(0, 6);
    step();
    enable[0] = 1'b1;
    step();
    for (int v = 0; v < 2; v++) begin
      set_div(0, v);
      step();
      n_cmp++;
      if (load_err !== 4'b0001 || load_ack !== '0 || e_err !== 4'b0001) begin
        n_err++;
        $display("FAIL load_err_v%0d: err=%b ack=%b required err=0001 ack=0000", v, load_err, load_ack);
      end
    end
    for (int i = 0; i < 14; i++) begin
      step();
      acks += int'(load_ack[0]);
      n_cmp++;
      if ({clkout, tick, busy, load_ack, load_err} !== {e_clk, e_tick, e_busy, e_ack, e_err}) begin
        n_err++;
        $display("FAIL load_err_run cyc%0d: outs=%h model=%h", i,
                 {clkout, tick, busy, load_ack, load_err}, {e_clk, e_tick, e_busy, e_ack, e_err});
      end
    end
    n_cmp++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL load_err_noack: acks=%0d required 0", acks);
    end
    // load arriving on the boundary cycle must wait one full extra period
    for (int i = 0; i < 12 && m_phase[0] != 5; i++) step();
    set_div(0, 4);
    step();
    n_cmp++;
    if (tick[0] !== 1'b1 || load_ack[0] !== 1'b0) begin
      n_err++;
      $display("FAIL defer_boundary: tick=%b ack=%b required tick=1 ack=0", tick[0], load_ack[0]);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 6 || i == 10) begin
        n_cmp++;
        if (tick[0] !== 1'b1 || load_ack[0] !== (i == 6)) begin
          n_err++;
          $display("FAIL defer_apply cyc%0d: tick=%b ack=%b required tick=1 ack=%0d", i, tick[0],
                   load_ack[0], (i == 6));
        end
      end
    end
  endtask

  task automatic test_sync();
    quiesce();
    set_div(0, 4);
    set_div(1, 7);
    step();
    enable[0] = 1'b1;
    step(); step(); step();
    enable[1] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    sync_start = 1'b1;
    step();
    n_cmp++;
    if (clkout[1:0] !== 2'b11 || tick[1:0] !== 2'b11 ||
        {clkout, tick, busy, load_ack, load_err} !== {e_clk, e_tick, e_busy, e_ack, e_err}) begin
      n_err++;
      $display("FAIL sync: clkout=%b tick=%b required 11 11 (model outs=%h got=%h)", clkout[1:0],
               tick[1:0], {e_clk, e_tick, e_busy, e_ack, e_err},
               {clkout, tick, busy, load_ack, load_err});
    end
  endtask

  task automatic test_disable_reset();
    quiesce();
    set_div(0, 8);
    step();
    enable[0] = 1'b1;
    step(); step();
    enable[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if (busy[0] !== (i < 6) ||
          {clkout, tick, busy, load_ack, load_err} !== {e_clk, e_tick, e_busy, e_ack, e_err}) begin
        n_err++;
        $display("FAIL disable cyc%0d: busy=%b required %0d outs=%h model=%h", i, busy[0], (i < 6),
                 {clkout, tick, busy, load_ack, load_err}, {e_clk, e_tick, e_busy, e_ack, e_err});
      end
    end
    enable[0] = 1'b1;
    set_div(0, 5);
    step();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (clkout !== '0 || busy !== '0 || tick !== '0) begin
      n_err++;
      $display("FAIL async_reset: clkout=%b busy=%b tick=%b required 0", clkout, busy, tick);
    end
    model_reset();
    @(negedge clkin);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (load_ack[0] !== 1'b0 || clkout[0] !== ((i % 2) == 0) ||
          {clkout, tick, busy, load_ack, load_err} !== {e_clk, e_tick, e_busy, e_ack, e_err}) begin
        n_err++;
        $display("FAIL post_reset cyc%0d: clk=%b ack=%b required clk=%0d ack=0", i, clkout[0],
                 load_ack[0], ((i % 2) == 0));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        enable[c] = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 9) == 0) set_div(c, int'($urandom_range(0, 9)));
      end
      sync_start = ($urandom_range(0, 19) == 0);
      step();
      n_cmp++;
      if ({clkout, tick, busy, load_ack, load_err} !== {e_clk, e_tick, e_busy, e_ack, e_err}) begin
        n_err++;
        $display("FAIL random cyc%0d: outs=%h model=%h", i,
                 {clkout, tick, busy, load_ack, load_err}, {e_clk, e_tick, e_busy, e_ack, e_err});
      end
    end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_reload();
    test_load_err();
    test_sync();
    test_disable_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
